// File: rtl/mac_rr_scheduler_pkg.sv
// Shared widths, arithmetic types and sizing helper for the multiply-add scheduler.
package mac_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int A_W_DEF   = 18;
  localparam int B_W_DEF   = 18;
  localparam int C_W_DEF   = 36;

  typedef logic [C_W_DEF-1:0] prod_t;
  typedef logic [C_W_DEF:0]   sum_t;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_rr_scheduler_if.sv
// Request/response bundle between the requesting engines and the shared multiply-add scheduler.
interface mac_rr_scheduler_if import mac_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int C_W   = C_W_DEF
);
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*A_W-1:0] req_a;
  logic [N_REQ*B_W-1:0] req_b;
  logic [N_REQ*C_W-1:0] req_c;
  logic [N_REQ-1:0]     rsp_valid;
  logic [N_REQ-1:0]     rsp_ready;
  logic [N_REQ*C_W-1:0] rsp_result;
  logic [N_REQ-1:0]     rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_overflow
  );
endinterface

// File: rtl/mac_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from a pointer that
// advances past the winner.
module rr_arbiter import mac_sched_pkg::*; #(
  parameter int N     = N_REQ_DEF,
  parameter int TAG_W = tag_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [TAG_W-1:0] grant_idx
);
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic             found_s;
  int               idx_s;

  // grant search starting at ptr_q with wrap-around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    idx_s     = 0;
    for (int off = 0; off < N; off++) begin
      idx_s = int'(ptr_q) + off;
      if (idx_s >= N) begin
        idx_s = idx_s - N;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s]) begin
        found_s        = 1'b1;
        grant[idx_s]   = 1'b1;
        grant_idx      = TAG_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // pointer moves only on a grant
  always_comb begin
    if (found_s) begin
      ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + TAG_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: rtl/mac_rr_scheduler.sv
// Shares one registered-product / registered-sum multiply-add among N_REQ requesters,
// one op per cycle, with a per-requester result holding register.
module mac_rr_scheduler import mac_sched_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int C_W   = C_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mac_rr_scheduler_if.slave   bus,
  output logic                idle
);
  localparam int TAG_W = tag_width(N_REQ);

  logic [N_REQ-1:0] busy_s, elig_s, grant_s;
  logic [TAG_W-1:0] grant_idx_s;

  logic             s1_v_q, s1_v_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [C_W-1:0]   s1_axb_q, s1_axb_d, s1_c_q, s1_c_d;
  logic [C_W:0]     sum_s;

  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d, rsp_ovf_q, rsp_ovf_d;
  logic [C_W-1:0]   rsp_res_q [N_REQ];
  logic [C_W-1:0]   rsp_res_d [N_REQ];
  logic [N_REQ*C_W-1:0] rsp_result_s;
  logic             idle_q, idle_d;

  // a requester is busy from grant until its held result is consumed; no grants during reset
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      busy_s[i] = rsp_valid_q[i] | (s1_v_q & (s1_tag_q == TAG_W'(i)));
      elig_s[i] = bus.req_valid[i] & ~busy_s[i] & ~reset;
    end
  end

  rr_arbiter #(.N(N_REQ), .TAG_W(TAG_W)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (elig_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // stage 1: operands of the granted requester, product formed here
  always_comb begin
    s1_v_d   = |grant_s;
    s1_tag_d = grant_idx_s;
    s1_axb_d = C_W'(bus.req_a[grant_idx_s*A_W +: A_W]) * C_W'(bus.req_b[grant_idx_s*B_W +: B_W]);
    s1_c_d   = bus.req_c[grant_idx_s*C_W +: C_W];
  end

  assign sum_s = {1'b0, s1_c_q} + {1'b0, s1_axb_q};

  // stage 2 lands directly in the holding register; exclusivity keeps the slot free
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i];
      rsp_ovf_d[i]   = rsp_ovf_q[i];
      rsp_res_d[i]   = rsp_res_q[i];
      if (s1_v_q && (s1_tag_q == TAG_W'(i))) begin
        rsp_valid_d[i] = 1'b1;
        rsp_ovf_d[i]   = sum_s[C_W];
        rsp_res_d[i]   = sum_s[C_W-1:0];
      end else if (rsp_valid_q[i] && bus.rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end else begin
        rsp_valid_d[i] = rsp_valid_q[i];
      end
    end
    idle_d = ~s1_v_d & ~(|rsp_valid_d);
  end

  // pipeline, holding and idle registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q      <= 1'b0;
      s1_tag_q    <= '0;
      s1_axb_q    <= '0;
      s1_c_q      <= '0;
      rsp_valid_q <= '0;
      rsp_ovf_q   <= '0;
      idle_q      <= 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_res_q[i] <= '0;
      end
    end else begin
      s1_v_q      <= s1_v_d;
      s1_tag_q    <= s1_tag_d;
      s1_axb_q    <= s1_axb_d;
      s1_c_q      <= s1_c_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ovf_q   <= rsp_ovf_d;
      idle_q      <= idle_d;
      for (int i = 0; i < N_REQ; i++) begin
        rsp_res_q[i] <= rsp_res_d[i];
      end
    end
  end

  // flatten held results onto the bus
  always_comb begin
    rsp_result_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_result_s[i*C_W +: C_W] = rsp_res_q[i];
    end
  end

  assign bus.req_ready    = grant_s;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_result   = rsp_result_s;
  assign idle             = idle_q;
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed and randomised checks of mac_rr_scheduler against a cycle-level behavioural model.
module tb_mac_rr_scheduler;
  localparam int N  = 4;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int CW = 36;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  logic idle;

  always #5 clk = ~clk;

  mac_rr_scheduler_if #(.N_REQ(N), .A_W(AW), .B_W(BW), .C_W(CW)) bus ();

  mac_rr_scheduler #(.N_REQ(N), .A_W(AW), .B_W(BW), .C_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .idle  (idle)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mac(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    return a * b + c;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = (r == -1) ? i : -2;
    end
    return r;
  endfunction

  // Model: per requester, edges left until its result is held, the held flag and value.
  bit          m_known = 1'b0;
  int          m_ptr;
  int          m_due  [N];
  bit          m_held [N];
  logic [63:0] m_pend [N];
  logic [63:0] m_val  [N];
  int          n_ops = 0;

  always @(negedge clk) begin : model_blk
    int k;
    logic [N-1:0] exp_rdy, exp_vld;
    bit exp_idle;
    k = -1;
    if (m_known) begin
      if (!reset) begin
        for (int off = 0; off < N; off++) begin
          int j;
          j = (m_ptr + off) % N;
          if (k < 0 && bus.req_valid[j] && m_due[j] == 0 && !m_held[j]) k = j;
        end
      end
      exp_rdy  = '0;
      exp_vld  = '0;
      exp_idle = 1'b1;
      if (k >= 0) exp_rdy[k] = 1'b1;
      for (int i = 0; i < N; i++) begin
        exp_vld[i] = m_held[i];
        if (m_held[i] || m_due[i] > 0) exp_idle = 1'b0;
      end
      check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_vld));
      check("idle", 64'(idle), 64'(exp_idle));
      for (int i = 0; i < N; i++) begin
        if (m_held[i]) begin
          check("rsp_result", 64'(bus.rsp_result[i*CW +: CW]), 64'(m_val[i][CW-1:0]));
          check("rsp_overflow", 64'(bus.rsp_overflow[i]), 64'(m_val[i][CW]));
        end
      end
    end
    if (reset) begin
      m_known = 1'b1;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) begin
        m_due[i]  = 0;
        m_held[i] = 1'b0;
      end
    end else if (m_known) begin
      for (int i = 0; i < N; i++) begin
        if (m_held[i] && bus.rsp_ready[i]) begin
          m_held[i] = 1'b0;
          n_ops++;
        end
        if (m_due[i] > 0) begin
          m_due[i]--;
          if (m_due[i] == 0) begin
            m_held[i] = 1'b1;
            m_val[i]  = m_pend[i];
          end
        end
      end
      if (k >= 0) begin
        // the first edge moves the op into the pipeline, so LAT-1 edges remain
        m_due[k]  = LAT - 1;
        m_pend[k] = mac(64'(bus.req_a[k*AW +: AW]), 64'(bus.req_b[k*BW +: BW]),
                        64'(bus.req_c[k*CW +: CW]));
        m_ptr     = (k + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    bus.req_a[i*AW +: AW] = AW'(a);
    bus.req_b[i*BW +: BW] = BW'(b);
    bus.req_c[i*CW +: CW] = CW'(c);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      set_op(i, 64'($urandom), 64'($urandom), {32'($urandom), 32'($urandom)});
    end
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b1;
    bus.req_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  int gseq [8];
  int exp_seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int cnt [N];
  int start_ops, cyc, first0, second0, g;
  logic [CW-1:0] held1;
  bit captured;

  initial begin
    reset            = 1'b1;
    bus.req_valid    = '0;
    bus.rsp_ready    = '0;
    bus.req_a        = '0;
    bus.req_b        = '0;
    bus.req_c        = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_result", 64'(|bus.rsp_result), 64'(0));
    check("rst_overflow", 64'(bus.rsp_overflow), 64'(0));
    check("rst_idle", 64'(idle), 64'(1));

    // single op 3*5+7
    tick();
    set_op(0, 64'd3, 64'd5, 64'd7);
    bus.req_valid = 4'b0001;
    @(negedge clk) check("t1_accept", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    @(negedge clk) check("t1_t1_valid", 64'(bus.rsp_valid), 64'h0);
    check("t1_t1_idle", 64'(idle), 64'h0);
    tick();
    @(negedge clk) check("t1_t2_valid", 64'(bus.rsp_valid), 64'h1);
    check("t1_result", 64'(bus.rsp_result[CW-1:0]), 64'd22);
    check("t1_overflow", 64'(bus.rsp_overflow[0]), 64'h0);
    check("t1_t2_idle", 64'(idle), 64'h0);
    tick();
    bus.rsp_ready = 4'b0001;
    @(negedge clk) check("t1_hs_idle", 64'(idle), 64'h0);
    tick();
    bus.rsp_ready = '0;
    @(negedge clk) check("t1_done_valid", 64'(bus.rsp_valid), 64'h0);
    check("t1_done_idle", 64'(idle), 64'h1);

    // overflow
    tick();
    set_op(0, 64'h3FFFF, 64'h3FFFF, 64'hF_FFFF_FFFF);
    bus.req_valid = 4'b0001;
    @(negedge clk) check("t2_accept", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    tick();
    @(negedge clk) check("t2_result", 64'(bus.rsp_result[CW-1:0]), 64'hF_FFF8_0000);
    check("t2_overflow", 64'(bus.rsp_overflow[0]), 64'h1);
    tick();
    bus.rsp_ready = 4'b1111;
    tick();
    bus.rsp_ready = '0;

    // fairness with everything valid and always ready
    pulse_reset();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      @(negedge clk) gseq[c] = oh_idx(bus.req_ready);
      tick();
    end
    first0 = -1;
    second0 = -1;
    for (int c = 0; c < 8; c++) begin
      check("fair_seq", 64'(gseq[c]), 64'(exp_seq[c]));
      if (gseq[c] == 0) begin
        if (first0 < 0) first0 = c;
        else if (second0 < 0) second0 = c;
      end
    end
    check("fair_regrant_gap", 64'(second0 - first0 >= 3), 64'h1);

    // starvation with random valid/ready
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      bus.req_valid = N'($urandom);
      bus.rsp_ready = N'($urandom);
      rand_ops();
      @(negedge clk) g = oh_idx(bus.req_ready);
      if (g >= 0) cnt[g]++;
      tick();
    end
    for (int i = 0; i < N; i++) check("no_starve", 64'(cnt[i] > 0), 64'h1);

    // backpressure on requester 1
    for (int i = 0; i < N; i++) cnt[i] = 0;
    captured = 1'b0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b1101;
    for (int c = 0; c < 20; c++) begin
      rand_ops();
      @(negedge clk);
      if (captured) begin
        check("bp_valid_stable", 64'(bus.rsp_valid[1]), 64'h1);
        check("bp_result_stable", 64'(bus.rsp_result[CW +: CW]), 64'(held1));
        check("bp_no_ready1", 64'(bus.req_ready[1]), 64'h0);
        g = oh_idx(bus.req_ready);
        if (g >= 0) cnt[g]++;
      end else if (bus.rsp_valid[1]) begin
        captured = 1'b1;
        held1 = bus.rsp_result[CW +: CW];
      end
      tick();
    end
    check("bp_held", 64'(captured), 64'h1);
    check("bp_others_served", 64'(cnt[0] > 0 && cnt[2] > 0 && cnt[3] > 0), 64'h1);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 4'b1111;
    @(negedge clk) check("bp_release_cycle", 64'(bus.req_ready), 64'h0);
    tick();
    @(negedge clk) check("bp_reissue", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();

    // reset with ops in flight
    pulse_reset();
    bus.rsp_ready = '0;
    bus.req_valid = 4'b0101;
    @(negedge clk) check("rm_accept0", 64'(bus.req_ready), 64'h1);
    tick();
    @(negedge clk) check("rm_accept2", 64'(bus.req_ready), 64'h4);
    tick();
    bus.req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk) check("rm_no_rsp", 64'(bus.rsp_valid), 64'h0);
      check("rm_idle", 64'(idle), 64'h1);
      tick();
    end
    bus.req_valid = 4'b1010;
    @(negedge clk) check("rm_ptr_zero", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 4'b1111;
    repeat (4) tick();

    // random scoreboard run
    start_ops = n_ops;
    cyc = 0;
    while ((n_ops - start_ops) < 10000 && cyc < 60000) begin
      bus.req_valid = N'($urandom | $urandom);
      bus.rsp_ready = N'($urandom);
      rand_ops();
      tick();
      cyc++;
    end
    check("sb_ops_done", 64'((n_ops - start_ops) >= 10000), 64'h1);
    bus.req_valid = '0;
    bus.rsp_ready = 4'b1111;
    repeat (5) tick();
    @(negedge clk) check("final_idle", 64'(idle), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
